// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// MULT/MULTU use LSB-first shift-add and DIV/DIVU use MSB-first restoring division.
// Each operation takes 32 CALC cycles and one FIX cycle. HI/LO change only in FIX or on MTHI/MTLO.
module mult_div_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] inpA,
   input  logic [31:0] inpB,
   input  logic        mthi,
   input  logic        mtlo,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned W     = 32;
   localparam int unsigned ACC_W = 2 * W;
   localparam int unsigned CNT_W = 6;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_e;

   state_e             state_q,   state_d;
   logic [CNT_W-1:0]   cnt_q,     cnt_d;
   logic               is_div_q,  is_div_d;
   logic               neg_res_q, neg_res_d;   // negate product / quotient
   logic               neg_rem_q, neg_rem_d;   // negate remainder (dividend sign)
   logic               b_zero_q,  b_zero_d;
   logic [W-1:0]       opnd_q,    opnd_d;      // multiplicand or divisor magnitude
   logic [W-1:0]       orig_a_q,  orig_a_d;    // raw dividend for divide-by-zero HI
   logic [ACC_W-1:0]   acc_q,     acc_d;       // product, or dividend shifting into quotient
   logic [W-1:0]       rem_q,     rem_d;       // settled partial remainder
   logic               busy_q,    busy_d;
   logic               done_q,    done_d;
   logic [W-1:0]       hi_q,      hi_d;
   logic [W-1:0]       lo_q,      lo_d;

   logic [W-1:0]       a_mag, b_mag;
   logic               sign_a, sign_b;
   logic [W:0]         mul_sum;
   logic [W:0]         div_part;
   logic               div_ge;
   logic [W-1:0]       div_diff;
   logic [ACC_W-1:0]   prod_fix;
   logic [W-1:0]       quo_fix, rem_fix;

   // Operand signs and magnitudes; only signed ops take magnitudes
   always_comb begin
      sign_a = op[0] & inpA[W-1];
      sign_b = op[0] & inpB[W-1];
      a_mag  = sign_a ? W'(-inpA) : inpA;
      b_mag  = sign_b ? W'(-inpB) : inpB;
   end

   // One iteration step for each algorithm, plus FIX-stage sign correction
   always_comb begin
      mul_sum  = {1'b0, acc_q[ACC_W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : (W+1)'(0));
      div_part = {rem_q, acc_q[W-1]};
      div_ge   = (div_part >= {1'b0, opnd_q});
      div_diff = W'(div_part - {1'b0, opnd_q});
      prod_fix = neg_res_q ? ACC_W'(-acc_q) : acc_q;
      quo_fix  = neg_res_q ? W'(-acc_q[W-1:0]) : acc_q[W-1:0];
      rem_fix  = neg_rem_q ? W'(-rem_q) : rem_q;
   end

   // Next-state and datapath updates
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      b_zero_d  = b_zero_q;
      opnd_d    = opnd_q;
      orig_a_d  = orig_a_q;
      acc_d     = acc_q;
      rem_d     = rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      busy_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = CALC;
               cnt_d     = '0;
               is_div_d  = op[1];
               neg_res_d = sign_a ^ sign_b;
               neg_rem_d = sign_a;
               b_zero_d  = (inpB == '0);
               orig_a_d  = inpA;
               rem_d     = '0;
               opnd_d    = op[1] ? b_mag : a_mag;
               acc_d     = {{W{1'b0}}, (op[1] ? a_mag : b_mag)};
            end else begin
               if (mthi) hi_d = inpA;
               if (mtlo) lo_d = inpA;
            end
         end
         CALC: begin
            if (is_div_q) begin
               acc_d = {acc_q[ACC_W-1:W], acc_q[W-2:0], div_ge};
               rem_d = div_ge ? div_diff : div_part[W-1:0];
            end else begin
               acc_d = {mul_sum, acc_q[W-1:1]};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) state_d = FIX;
         end
         FIX: begin
            if (!is_div_q) begin
               hi_d = prod_fix[ACC_W-1:W];
               lo_d = prod_fix[W-1:0];
            end else if (b_zero_q) begin
               hi_d = orig_a_q;
               lo_d = '1;
            end else begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and datapath registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         b_zero_q  <= 1'b0;
         opnd_q    <= '0;
         orig_a_q  <= '0;
         acc_q     <= '0;
         rem_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         b_zero_q  <= b_zero_d;
         opnd_q    <= opnd_d;
         orig_a_q  <= orig_a_d;
         acc_q     <= acc_d;
         rem_q     <= rem_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
